quad_gate_tester: RTL

- Sequencer that drives a quad 2-input gate chip (74xx-style: pins 1/2, 4/5, 9/10, 12/13 in; pins 3, 6, 8, 11 out) through all four input combinations.
- Samples the chip outputs after a settle delay and compares them against the expected function for a selected gate type.
- Reports a per-gate pass/fail mask.
- Sits between board controls (switches/keys) and the chip model, or a real chip on the GPIO header. It owns the chip's inputs for the duration of a test run.

---
 rtl/quad_gate_pkg.sv | 31 +++
 rtl/quad_gate_tester_if.sv | 13 +
 rtl/quad_gate_expect.sv | 20 ++
 rtl/quad_gate_tester.sv | 87 ++++++++
 4 files changed

// File: rtl/quad_gate_pkg.sv
// Shared constants for the quad 2-input gate tester: gate types, FSM encoding
// and the chip pin map.
package quad_gate_pkg;

  localparam int NUM_GATES = 4;

  localparam logic [1:0] GATE_OR   = 2'd0;
  localparam logic [1:0] GATE_AND  = 2'd1;
  localparam logic [1:0] GATE_XOR  = 2'd2;
  localparam logic [1:0] GATE_NAND = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    SAMPLE = ST_SAMPLE,
    DONE   = ST_DONE
  } state_t;

  // chip_in bit carrying each gate's A and B input, and the package pins behind them
  localparam int GATE_A_BIT [NUM_GATES] = '{0, 2, 4, 6};
  localparam int GATE_B_BIT [NUM_GATES] = '{1, 3, 5, 7};
  localparam int GATE_A_PIN [NUM_GATES] = '{1, 4, 9, 12};
  localparam int GATE_B_PIN [NUM_GATES] = '{2, 5, 10, 13};
  localparam int GATE_Y_PIN [NUM_GATES] = '{3, 6, 8, 11};

endpackage

// File: rtl/quad_gate_tester_if.sv
// Board-side control/status bundle of the gate tester.
interface quad_gate_tester_if;
  logic       start;
  logic [1:0] gate_sel;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [1:0] vec;

  modport master (output start, gate_sel, input busy, done, pass, fail_mask, vec);
  modport slave  (input start, gate_sel, output busy, done, pass, fail_mask, vec);
endinterface

// File: rtl/quad_gate_expect.sv
// Reference output of one 2-input gate of the selected type.
import quad_gate_pkg::*;

module quad_gate_expect (
  input  logic [1:0] gate_sel,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  always_comb begin
    y = 1'b0;
    case (gate_sel)
      GATE_OR:   y = a | b;
      GATE_AND:  y = a & b;
      GATE_XOR:  y = a ^ b;
      GATE_NAND: y = ~(a & b);
      default:   y = 1'b0;
    endcase
  end
endmodule

// File: rtl/quad_gate_tester.sv
// Walks a quad 2-input gate chip through its four input vectors, holding each
// for SETTLE_CYCLES before sampling, and accumulates a sticky per-gate fail mask.
import quad_gate_pkg::*;

module quad_gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  quad_gate_tester_if.slave    ctl,
  output logic [7:0]           chip_in,
  input  logic [NUM_GATES-1:0] chip_out
);
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t               state, state_n;
  logic [7:0]           cnt, cnt_n;
  logic [1:0]           v, v_n;
  logic [1:0]           gsel, gsel_n;
  logic [NUM_GATES-1:0] mask, mask_n;
  logic                 y;

  quad_gate_expect u_expect (.gate_sel(gsel), .a(v[1]), .b(v[0]), .y(y));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      v     <= '0;
      gsel  <= '0;
      mask  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      v     <= v_n;
      gsel  <= gsel_n;
      mask  <= mask_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    v_n     = v;
    gsel_n  = gsel;
    mask_n  = mask;
    case (state)
      IDLE, DONE: begin
        if (ctl.start) begin
          gsel_n  = ctl.gate_sel;
          v_n     = 2'd0;
          mask_n  = '0;
          cnt_n   = CNT_LOAD;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == 8'd0) state_n = SAMPLE;
        else             cnt_n   = cnt - 8'd1;
      end
      SAMPLE: begin
        // the last vector's sample is folded in before DONE reports pass
        mask_n = mask | (chip_out ^ {NUM_GATES{y}});
        if (v == 2'd3) begin
          state_n = DONE;
        end else begin
          v_n     = v + 2'd1;
          cnt_n   = CNT_LOAD;
          state_n = SETTLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // v is 0 in IDLE, so the pattern alone gives chip_in=0 after reset
  for (genvar g = 0; g < NUM_GATES; g++) begin : g_pins
    assign chip_in[GATE_A_BIT[g]] = v[1];
    assign chip_in[GATE_B_BIT[g]] = v[0];
  end

  assign ctl.busy      = (state == SETTLE) || (state == SAMPLE);
  assign ctl.done      = (state == DONE);
  assign ctl.pass      = (state == DONE) && (mask == '0);
  assign ctl.fail_mask = mask;
  assign ctl.vec       = v;
endmodule
